// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / HI-LO interlock and branch squash controller for a 5-stage pipeline
module pipe_hazard_ctrl #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_muldiv,
    input  logic              id_reads_hilo,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch_taken,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              muldiv_issue,
    output logic              muldiv_busy,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_BUSY = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;
    logic             hilo_wait;

    // ex_rd == 0 never hazards, which also covers id_rs/id_rt == $zero
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign hilo_wait   = (state == ST_MD_BUSY) && (id_reads_hilo || id_muldiv);
    assign muldiv_busy = (state == ST_MD_BUSY);

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        muldiv_issue = 1'b0;
        if (reset) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (load_use || hilo_wait) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            muldiv_issue = id_muldiv && (state == ST_RUN);
        end
    end

    // A taken branch leaves MD_BUSY running: the MULT/DIV is older than the branch
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (muldiv_issue) begin
            state_nxt = ST_MD_BUSY;
            cnt_nxt   = CNT_W'(MULDIV_LAT - 1);
        end else if (state == ST_MD_BUSY) begin
            cnt_nxt = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (!pc_en && (stall_cnt != {PERF_W{1'b1}})) begin
                stall_cnt <= stall_cnt + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int LAT   = 32;
    localparam int CW    = 6;
    localparam int PW    = 8;
    localparam int S_MAX = (1 << PW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, id_muldiv, id_reads_hilo;
    logic          ex_mem_read, ex_branch_taken;
    logic          pc_en, if_id_en, if_id_flush, id_ex_bubble;
    logic          muldiv_issue, muldiv_busy;
    logic [PW-1:0] stall_cnt;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CW), .PERF_W(PW)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_muldiv(id_muldiv), .id_reads_hilo(id_reads_hilo),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .muldiv_issue(muldiv_issue),
        .muldiv_busy(muldiv_busy), .stall_cnt(stall_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model: cycles of MULT/DIV occupancy left, and stalled-cycle tally
    int   m_busy_rem = 0;
    int   m_stall    = 0;
    logic e_pc, e_ifen, e_flush, e_bub, e_issue;

    typedef struct {
        logic [4:0] rs, rt, rd;
        logic urs, urt, mul, hilo, mr, br;
        logic pc, ifen, fl, bub, iss;
    } row_t;
    row_t tbl[10];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 0; id_rt = 0; ex_rd = 0;
        id_uses_rs = 0; id_uses_rt = 0; id_muldiv = 0; id_reads_hilo = 0;
        ex_mem_read = 0; ex_branch_taken = 0;
    endtask

    task automatic compute_expected();
        logic lu, hw;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        hw = (m_busy_rem > 0) && (id_reads_hilo || id_muldiv);
        if (reset)                {e_pc, e_ifen, e_flush, e_bub, e_issue} = 5'b00110;
        else if (ex_branch_taken) {e_pc, e_ifen, e_flush, e_bub, e_issue} = 5'b11110;
        else if (lu || hw)        {e_pc, e_ifen, e_flush, e_bub, e_issue} = 5'b00010;
        else {e_pc, e_ifen, e_flush, e_bub, e_issue} = {4'b1100, id_muldiv && m_busy_rem == 0};
    endtask

    task automatic half_a();
        @(negedge clock);
        compute_expected();
        chk("pc_en", pc_en, e_pc);
        chk("if_id_en", if_id_en, e_ifen);
        chk("if_id_flush", if_id_flush, e_flush);
        chk("id_ex_bubble", id_ex_bubble, e_bub);
        chk("muldiv_issue", muldiv_issue, e_issue);
        chk("muldiv_busy", muldiv_busy, m_busy_rem > 0);
        chk("stall_cnt", stall_cnt, m_stall);
    endtask

    task automatic half_b();
        @(posedge clock);
        if (reset) begin
            m_busy_rem = 0;
            m_stall    = 0;
        end else begin
            if (e_issue) m_busy_rem = LAT - 1;
            else if (m_busy_rem > 0) m_busy_rem--;
            if (!e_pc && m_stall < S_MAX) m_stall++;
        end
        #1;
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic issue_muldiv();
        id_muldiv = 1;
        half_a();
        chk("issue_pulse", muldiv_issue, 1);
        half_b();
        id_muldiv = 0;
    endtask

    function automatic row_t mk(input logic [4:0] rs, rt, rd, input logic urs, urt, mul,
                                hilo, mr, br, input logic [4:0] exp);
        row_t r;
        r.rs = rs; r.rt = rt; r.rd = rd; r.urs = urs; r.urt = urt; r.mul = mul;
        r.hilo = hilo; r.mr = mr; r.br = br;
        {r.pc, r.ifen, r.fl, r.bub, r.iss} = exp;
        return r;
    endfunction

    initial begin
        int n;
        clear_inputs();

        // reset held three cycles
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            half_a();
            chk("rst_pc_en", pc_en, 0);
            chk("rst_flush", if_id_flush, 1);
            chk("rst_bubble", id_ex_bubble, 1);
            half_b();
        end
        reset = 0;
        half_a();
        chk("post_rst_stall_cnt", stall_cnt, 0);
        chk("post_rst_busy", muldiv_busy, 0);
        half_b();

        // single-cycle vectors from RUN
        tbl[0] = mk(8, 0, 8, 1, 0, 0, 0, 1, 0, 5'b00010);
        tbl[1] = mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 5'b11000);
        tbl[2] = mk(0, 8, 8, 0, 1, 0, 0, 1, 0, 5'b00010);
        tbl[3] = mk(8, 0, 8, 0, 0, 0, 0, 1, 0, 5'b11000);
        tbl[4] = mk(8, 0, 8, 1, 0, 0, 0, 0, 0, 5'b11000);
        tbl[5] = mk(8, 0, 8, 1, 0, 0, 0, 1, 1, 5'b11110);
        tbl[6] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 5'b11110);
        tbl[7] = mk(3, 0, 3, 1, 0, 1, 0, 1, 0, 5'b00010);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11000);
        tbl[9] = mk(9, 0, 8, 1, 0, 0, 0, 1, 0, 5'b11000);
        for (int i = 0; i < 10; i++) begin
            id_rs = tbl[i].rs; id_rt = tbl[i].rt; ex_rd = tbl[i].rd;
            id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt; id_muldiv = tbl[i].mul;
            id_reads_hilo = tbl[i].hilo; ex_mem_read = tbl[i].mr; ex_branch_taken = tbl[i].br;
            half_a();
            chk($sformatf("tbl%0d_pc_en", i), pc_en, tbl[i].pc);
            chk($sformatf("tbl%0d_if_id_en", i), if_id_en, tbl[i].ifen);
            chk($sformatf("tbl%0d_flush", i), if_id_flush, tbl[i].fl);
            chk($sformatf("tbl%0d_bubble", i), id_ex_bubble, tbl[i].bub);
            chk($sformatf("tbl%0d_issue", i), muldiv_issue, tbl[i].iss);
            half_b();
        end

        // load-use for one cycle
        do_reset();
        ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
        half_a();
        chk("lu_pc_en", pc_en, 0);
        chk("lu_bubble", id_ex_bubble, 1);
        half_b();
        clear_inputs();
        half_a();
        chk("lu_release", pc_en, 1);
        chk("lu_stall_cnt", stall_cnt, 1);
        half_b();

        // MULT then MFHI: stalled LAT-1 cycles
        do_reset();
        issue_muldiv();
        id_reads_hilo = 1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            half_a();
            if (pc_en) break;
            n++;
            half_b();
        end
        chk("mfhi_stall_cycles", n, LAT - 1);
        chk("mfhi_stall_cnt", stall_cnt, LAT - 1);
        chk("mfhi_busy_done", muldiv_busy, 0);
        half_b();
        clear_inputs();

        // taken branch while busy does not disturb the countdown
        do_reset();
        issue_muldiv();
        for (int i = 0; i < 5; i++) step();
        ex_branch_taken = 1; id_reads_hilo = 1;
        half_a();
        chk("br_busy_flush", if_id_flush, 1);
        chk("br_busy_pc_en", pc_en, 1);
        chk("br_busy_busy", muldiv_busy, 1);
        half_b();
        clear_inputs();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            half_a();
            if (!muldiv_busy) break;
            n++;
            half_b();
        end
        chk("br_busy_remaining", n, LAT - 1 - 6);
        half_b();

        // reset mid-operation returns to RUN with a fresh counter
        do_reset();
        issue_muldiv();
        for (int i = 0; i < 5; i++) step();
        do_reset();
        half_a();
        chk("rst_mid_busy", muldiv_busy, 0);
        half_b();
        issue_muldiv();
        n = 0;
        for (int i = 0; i < 100; i++) begin
            half_a();
            if (!muldiv_busy) break;
            n++;
            half_b();
        end
        chk("rst_mid_reissue_len", n, LAT - 1);
        half_b();

        // stall counter saturates
        do_reset();
        ex_mem_read = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1;
        for (int i = 0; i < S_MAX + 40; i++) step();
        half_a();
        chk("stall_cnt_sat", stall_cnt, S_MAX);
        half_b();

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 63) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_muldiv       = ($urandom_range(0, 5) == 0);
            id_reads_hilo   = ($urandom_range(0, 3) == 0);
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
